load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator for the core's byte-lane data memory; the memory is the responder.
- Accepts one load/store request at a time from the execute stage with a valid/ready handshake.
- Drives the memory's address, write-data, write-mask and read-mask inputs, then returns a formatted result with an error flag.
- Checks alignment before issuing any memory access. Sits between execute and writeback.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; only 32 supported

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&ready at posedge
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- i_req_signed  in  1  sign-extend load result
- o_resp_valid  out  1  response present
- i_resp_ready  in  1  response consumed when valid&ready at posedge
- o_resp_rdata  out  32  load result; 0 for stores
- o_resp_err  out  1  misaligned, illegal size, or memory-reported error
- o_mem_address  out  32  to memory address input
- o_mem_wr_data  out  32  to memory write-data input
- o_mem_wr_mask  out  2  N=0, B=1, H=2, W=3
- o_mem_rd_mask  out  3  W=0, HZ=1, BZ=2, HE=3, BE=4, XX=5
- i_mem_rd_data  in  32  memory read data, valid the cycle after the address
- i_mem_err_misaligned  in  1  memory error flag
- i_mem_err_invalid_rd_mask  in  1  memory error flag

Behaviour:
- States: IDLE, ACCESS, LATCH, RESP, ERR_RESP. With MISALIGNED_SPLIT_EN, also ACC_LO, ACC_HI.
- Reset (synchronous, any state):
  - state=IDLE.
  - o_req_ready=1, o_resp_valid=0, o_resp_rdata=0, o_resp_err=0.
  - o_mem_wr_mask=N, o_mem_rd_mask=XX, o_mem_address=0, o_mem_wr_data=0.
  - Any in-flight request and pending response are dropped; no memory write may issue in the cycle after reset.
- IDLE:
  - o_req_ready=1. Memory is driven with wr_mask=N and rd_mask=XX.
  - On accept, register addr, wdata, we, size and signed.
  - Aligned means: byte always; half needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned or size=3 goes to ERR_RESP; no memory access is issued.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - o_mem_address = registered addr.
  - Stores: wr_mask = B/H/W by size; rd_mask=XX; wr_data = registered wdata.
  - Loads: wr_mask=N; rd_mask = W for word, HZ/HE for half, BZ/BE for byte, with the E variant selected by signed.
  - Next state LATCH.
- LATCH (one cycle):
  - Memory signals return to N/XX.
  - Register o_resp_rdata = i_mem_rd_data for loads, 0 for stores.
  - Register o_resp_err = i_mem_err_misaligned | i_mem_err_invalid_rd_mask.
  - Next state RESP.
- RESP:
  - o_resp_valid=1; rdata and err are held stable while not consumed.
  - On i_resp_ready go to IDLE. The next request may be accepted in the cycle after the handshake.
- ERR_RESP: o_resp_valid=1, o_resp_err=1, o_resp_rdata=0; on i_resp_ready go to IDLE.
- Latency: an aligned access presents o_resp_valid 3 cycles after the accept edge. Throughput is one request per 4 cycles with i_resp_ready held high.
- o_req_ready=0 in every state except IDLE. A request held during that time is accepted on return to IDLE.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: misaligned loads (half at addr[1:0]=3, word at addr[1:0]!=0) take this path instead of ERR_RESP.
  - IDLE -> ACC_LO: rd_mask=W at address {addr[31:2],00}.
  - ACC_HI: rd_mask=W at address +4; capture the low word in this same cycle.
  - LATCH: capture the high word.
  - Merge as ({hi,lo} >> 8*addr[1:0]), truncate to size, zero/sign-extend, then RESP. Load latency is 4 cycles.
  - Half at addr[1:0]=1 is not split; it uses the normal aligned path.
  - Misaligned stores still go to ERR_RESP.
  - Address +4 wraps modulo 2^32.
- Undefined: all misaligned requests go to ERR_RESP. The ACC_LO/ACC_HI states and merge logic are absent.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata=0xDEADBEEF, err=0, o_resp_valid 3 cycles after each accept.
- Store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; load unsigned -> 0x00000080.
- Load half @0x11 and store word @0x12, feature off -> ERR_RESP with err=1, rdata=0, o_mem_wr_mask stays N for the whole request.
- Feature on: words 0x44332211 @0x20 and 0x88776655 @0x24, load word @0x21 -> 0x55443322; load half signed @0x23 -> 0x00005544.
- Hold i_resp_ready=0 for 5 cycles in RESP -> rdata/err stable, o_req_ready=0, memory driven N/XX; the next request is accepted the cycle after the handshake.
- Assert i_reset during ACCESS of a store -> next cycle IDLE, wr_mask=N; a following load of the same address returns the prior value.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator between the execute stage and a byte-lane data memory. Takes
//   one load/store at a time (valid/ready), checks alignment, drives one
//   memory access, then returns a formatted load result plus an error flag.
//
//   Optional build macro: MISALIGNED_SPLIT_EN
//     When defined, misaligned loads (word at addr[1:0]!=0, half at
//     addr[1:0]==3) are served as two aligned word reads that are merged.
//     When undefined, every misaligned request returns an error.
//
//   Ports
//     i_clk, i_reset          clock, synchronous active-high reset
//     i_req_*, o_req_ready    request from execute (addr, wdata, we, size, signed)
//     o_resp_*, i_resp_ready  response to writeback (rdata, err)
//     o_mem_*                 address / write data / write mask / read mask
//     i_mem_*                 read data (cycle after address) and error flags
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_wr_data,
  output logic [1:0]        o_mem_wr_mask,
  output logic [2:0]        o_mem_rd_mask,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  input  logic              i_mem_err_misaligned,
  input  logic              i_mem_err_invalid_rd_mask
);

  localparam logic [1:0] WM_N = 2'd0, WM_B = 2'd1, WM_H = 2'd2, WM_W = 2'd3;
  localparam logic [2:0] RM_W = 3'd0, RM_HZ = 3'd1, RM_BZ = 3'd2,
                         RM_HE = 3'd3, RM_BE = 3'd4, RM_XX = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_LATCH, S_RESP, S_ERR_RESP
`ifdef MISALIGNED_SPLIT_EN
    , S_ACC_LO, S_ACC_HI
`endif
  } state_t;

  function automatic logic [2:0] load_rd_mask(input logic [1:0] size, input logic sgn);
    case (size)
      2'd0:    load_rd_mask = sgn ? RM_BE : RM_BZ;
      2'd1:    load_rd_mask = sgn ? RM_HE : RM_HZ;
      default: load_rd_mask = RM_W;
    endcase
  endfunction

  function automatic logic [1:0] store_wr_mask(input logic [1:0] size);
    case (size)
      2'd0:    store_wr_mask = WM_B;
      2'd1:    store_wr_mask = WM_H;
      default: store_wr_mask = WM_W;
    endcase
  endfunction

  // The registered request address and store data live directly in the
  // memory-facing output registers; only the load/store flag is kept apart.
  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_wr_mask_q, mem_wr_mask_d;
  logic [2:0]          mem_rd_mask_q, mem_rd_mask_d;
  logic                we_q, we_d;

  logic req_misaligned, req_illegal, req_err, mem_err;

  assign req_misaligned = ((i_req_size == 2'd1) && i_req_addr[0]) ||
                          ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
  assign req_illegal    = (i_req_size == 2'd3);
  assign mem_err        = i_mem_err_misaligned | i_mem_err_invalid_rd_mask;

`ifdef MISALIGNED_SPLIT_EN
  logic              req_split, req_half_odd_load;
  logic              split_q, split_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] merge_shift, merge_data;

  assign req_split = !i_req_we &&
                     (((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00)) ||
                      ((i_req_size == 2'd1) && (i_req_addr[1:0] == 2'b11)));
  // A half load at offset 1 stays inside one word, so it goes to memory as-is.
  assign req_half_odd_load = !i_req_we && (i_req_size == 2'd1) && (i_req_addr[1:0] == 2'b01);
  assign req_err = req_illegal | (req_misaligned & ~req_split & ~req_half_odd_load);

  // High word arrives on i_mem_rd_data during LATCH; low word was captured in ACC_HI.
  always_comb begin
    merge_shift = DATA_W'({i_mem_rd_data, lo_q} >> {off_q, 3'b000});
    if (size_q == 2'd1)
      merge_data = signed_q ? {{(DATA_W-16){merge_shift[15]}}, merge_shift[15:0]}
                            : {{(DATA_W-16){1'b0}}, merge_shift[15:0]};
    else
      merge_data = merge_shift;
  end
`else
  assign req_err = req_illegal | req_misaligned;
`endif

  always_comb begin
    state_d       = state_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wr_mask_d = WM_N;
    mem_rd_mask_d = RM_XX;
    we_d          = we_q;
`ifdef MISALIGNED_SPLIT_EN
    split_d  = split_q;
    off_d    = off_q;
    size_d   = size_q;
    signed_d = signed_q;
    lo_d     = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          we_d = i_req_we;
`ifdef MISALIGNED_SPLIT_EN
          split_d  = req_split;
          off_d    = i_req_addr[1:0];
          size_d   = i_req_size;
          signed_d = i_req_signed;
`endif
          if (req_err) begin
            state_d      = S_ERR_RESP;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end
`ifdef MISALIGNED_SPLIT_EN
          else if (req_split) begin
            state_d       = S_ACC_LO;
            mem_addr_d    = {i_req_addr[ADDR_W-1:2], 2'b00};
            mem_rd_mask_d = RM_W;
          end
`endif
          else begin
            state_d    = S_ACCESS;
            mem_addr_d = i_req_addr;
            if (i_req_we) begin
              mem_wr_mask_d = store_wr_mask(i_req_size);
              mem_wdata_d   = i_req_wdata;
            end else begin
              mem_rd_mask_d = load_rd_mask(i_req_size, i_req_signed);
            end
          end
        end
      end
      S_ACCESS: state_d = S_LATCH;
`ifdef MISALIGNED_SPLIT_EN
      S_ACC_LO: begin
        state_d       = S_ACC_HI;
        mem_addr_d    = mem_addr_q + ADDR_W'(4);  // wraps modulo 2^ADDR_W
        mem_rd_mask_d = RM_W;
      end
      S_ACC_HI: begin
        state_d    = S_LATCH;
        lo_d       = i_mem_rd_data;
        resp_err_d = mem_err;
      end
`endif
      S_LATCH: begin
        state_d      = S_RESP;
        resp_rdata_d = we_q ? '0 : i_mem_rd_data;
        resp_err_d   = mem_err;
`ifdef MISALIGNED_SPLIT_EN
        if (split_q) begin
          resp_rdata_d = merge_data;
          resp_err_d   = resp_err_q | mem_err;
        end
`endif
      end
      S_RESP, S_ERR_RESP: if (i_resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR_RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wr_mask_q <= WM_N;
      mem_rd_mask_q <= RM_XX;
      we_q          <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      split_q  <= 1'b0;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lo_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wr_mask_q <= mem_wr_mask_d;
      mem_rd_mask_q <= mem_rd_mask_d;
      we_q          <= we_d;
`ifdef MISALIGNED_SPLIT_EN
      split_q  <= split_d;
      off_q    <= off_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lo_q     <= lo_d;
`endif
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_resp_valid  = resp_valid_q;
  assign o_resp_rdata  = resp_rdata_q;
  assign o_resp_err    = resp_err_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_wr_data = mem_wdata_q;
  // A store whose ACCESS cycle coincides with reset must not commit: the
  // memory samples the mask on the same edge that applies the reset.
  assign o_mem_wr_mask = i_reset ? WM_N : mem_wr_mask_q;
  assign o_mem_rd_mask = mem_rd_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small byte-lane memory
// responder. Expected values are hand-computed constants.
module tb_load_store_unit;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_signed;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] mem_rdata;
  logic        mem_err_mis;
  logic        mem_err_inv;

  always #5 i_clk = ~i_clk;

  load_store_unit dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_we(i_req_we),
    .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(mem_rdata), .i_mem_err_misaligned(mem_err_mis),
    .i_mem_err_invalid_rd_mask(mem_err_inv)
  );

  // Byte-lane memory: 256 bytes (address bits [7:0]), writes on the edge that
  // ends the address cycle, read data and errors valid the following cycle.
  logic [7:0] mem_b [0:255];
  logic       mem_init;
  logic [7:0] ma;
  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'(i);
      mem_rdata   <= '0;
      mem_err_mis <= 1'b0;
      mem_err_inv <= 1'b0;
    end else begin
      ma = o_mem_address[7:0];
      case (o_mem_wr_mask)
        2'd1: mem_b[ma] <= o_mem_wr_data[7:0];
        2'd2: begin
          mem_b[ma] <= o_mem_wr_data[7:0]; mem_b[ma+8'd1] <= o_mem_wr_data[15:8];
        end
        2'd3: begin
          mem_b[ma]      <= o_mem_wr_data[7:0];   mem_b[ma+8'd1] <= o_mem_wr_data[15:8];
          mem_b[ma+8'd2] <= o_mem_wr_data[23:16]; mem_b[ma+8'd3] <= o_mem_wr_data[31:24];
        end
        default: ;
      endcase
      mem_rdata   <= '0;
      mem_err_mis <= 1'b0;
      mem_err_inv <= (o_mem_rd_mask > 3'd5);
      case (o_mem_rd_mask)
        3'd0: if (ma[1:0] != 2'b00) mem_err_mis <= 1'b1;
              else mem_rdata <= {mem_b[ma+8'd3], mem_b[ma+8'd2], mem_b[ma+8'd1], mem_b[ma]};
        3'd1: if (ma[0]) mem_err_mis <= 1'b1;
              else mem_rdata <= {16'h0, mem_b[ma+8'd1], mem_b[ma]};
        3'd3: if (ma[0]) mem_err_mis <= 1'b1;
              else mem_rdata <= {{16{mem_b[ma+8'd1][7]}}, mem_b[ma+8'd1], mem_b[ma]};
        3'd2: mem_rdata <= {24'h0, mem_b[ma]};
        3'd4: mem_rdata <= {{24{mem_b[ma][7]}}, mem_b[ma]};
        default: ;
      endcase
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request: drive, wait for accept, count cycles to o_resp_valid,
  // optionally hold i_resp_ready low for 'stall' cycles, then handshake.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int waits, output logic wr_seen, output logic stall_ok);
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_signed = sgn;
    i_req_addr = addr; i_req_wdata = wdata;
    waits = 0;
    while (!o_req_ready && waits < 20) begin
      @(negedge i_clk);
      waits++;
    end
    if (waits >= 20) check_eq({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge i_clk);
    #1;
    i_req_valid  = 1'b0;
    i_resp_ready = (stall == 0);
    lat = 0; wr_seen = 1'b0;
    do begin
      @(negedge i_clk);
      lat++;
      if (o_mem_wr_mask != 2'd0) wr_seen = 1'b1;
    end while (!o_resp_valid && lat < 20);
    if (!o_resp_valid) check_eq({name, "_resp_timeout"}, 32'd0, 32'd1);
    rdata = o_resp_rdata; err = o_resp_err;
    stall_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge i_clk);
      if (o_resp_valid !== 1'b1 || o_resp_rdata !== rdata || o_resp_err !== err ||
          o_req_ready !== 1'b0 || o_mem_wr_mask !== 2'd0 || o_mem_rd_mask !== 3'd5)
        stall_ok = 1'b0;
    end
    i_resp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    $display("txn %-12s we=%0d size=%0d sgn=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             name, we, size, sgn, addr, wdata, rdata, err, lat);
  endtask

  logic [31:0] r_data;
  logic        r_err, r_wr, r_stall;
  int          r_lat, r_waits;

  task automatic run(input string name, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    do_req(name, we, size, sgn, addr, wdata, 0, r_data, r_err, r_lat, r_waits, r_wr, r_stall);
    check_eq({name, "_rdata"}, r_data, exp_rdata);
    check_eq({name, "_err"}, {31'd0, r_err}, {31'd0, exp_err});
    check_eq({name, "_lat"}, 32'(r_lat), 32'(exp_lat));
    check_eq({name, "_wrmask"}, {31'd0, r_wr}, {31'd0, we & ~exp_err});
  endtask

  initial begin
    i_reset = 1'b1; mem_init = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_req_we = 1'b0;
    i_req_size = 2'd0; i_req_signed = 1'b0; i_resp_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0; mem_init = 1'b0;
    @(negedge i_clk);
    check_eq("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check_eq("rst_rdata", o_resp_rdata, 32'd0);
    check_eq("rst_err", {31'd0, o_resp_err}, 32'd0);
    check_eq("rst_wr_mask", {30'd0, o_mem_wr_mask}, 32'd0);
    check_eq("rst_rd_mask", {29'd0, o_mem_rd_mask}, 32'd5);
    check_eq("rst_addr", o_mem_address, 32'd0);
    check_eq("rst_wdata", o_mem_wr_data, 32'd0);

    // name            we    size  sgn   addr        wdata         exp_rdata     err   lat
    run("sw_10",      1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3);
    run("lw_10",      1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3);
    run("sb_13",      1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0, 3);
    run("lb_13",      1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3);
    run("lbu_13",     1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, 3);
    run("lhu_12",     1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h000080AD, 1'b0, 3);
    run("lh_12",      1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 3);
`ifdef MISALIGNED_SPLIT_EN
    run("lh_11",      1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 3);
`else
    run("lh_11",      1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1);
`endif
    run("sw_12",      1'b1, 2'd2, 1'b0, 32'h12, 32'h11111111, 32'h0,        1'b1, 1);
    run("size3",      1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1);
    run("lw_10_b",    1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 3);
    run("sw_20",      1'b1, 2'd2, 1'b0, 32'h20, 32'h44332211, 32'h0,        1'b0, 3);
    run("sw_24",      1'b1, 2'd2, 1'b0, 32'h24, 32'h88776655, 32'h0,        1'b0, 3);
    run("lh_22",      1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h00004433, 1'b0, 3);
`ifdef MISALIGNED_SPLIT_EN
    run("lw_21",      1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        32'h55443322, 1'b0, 4);
    run("lh_23",      1'b0, 2'd1, 1'b1, 32'h23, 32'h0,        32'h00005544, 1'b0, 4);
    run("lw_wrap",    1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0,  32'h0100FFFE, 1'b0, 4);
    run("sw_21",      1'b1, 2'd2, 1'b0, 32'h21, 32'h0,        32'h0,        1'b1, 1);
`else
    run("lw_21",      1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        32'h0,        1'b1, 1);
    run("lh_23",      1'b0, 2'd1, 1'b1, 32'h23, 32'h0,        32'h0,        1'b1, 1);
`endif

    // Response back-pressure for five cycles, then an immediate follow-up request.
    do_req("lw_stall", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r_data, r_err, r_lat, r_waits, r_wr, r_stall);
    check_eq("stall_stable", {31'd0, r_stall}, 32'd1);
    check_eq("stall_rdata", r_data, 32'h80ADBEEF);
    do_req("lbu_next", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, r_data, r_err, r_lat, r_waits, r_wr, r_stall);
    check_eq("next_waits", 32'(r_waits), 32'd0);
    check_eq("next_rdata", r_data, 32'h000000EF);

    // Reset applied during the ACCESS cycle of a store: the store is dropped.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2; i_req_signed = 1'b0;
    i_req_addr = 32'h10; i_req_wdata = 32'h12345678;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    check_eq("rstacc_wr_mask", {30'd0, o_mem_wr_mask}, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check_eq("rstacc_req_ready", {31'd0, o_req_ready}, 32'd1);
    check_eq("rstacc_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check_eq("rstacc_wr_mask2", {30'd0, o_mem_wr_mask}, 32'd0);
    check_eq("rstacc_rd_mask", {29'd0, o_mem_rd_mask}, 32'd5);
    run("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,      32'h80ADBEEF, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
